// File: rtl/kmap_sweep_capture.sv
// kmap_sweep_capture
// Walks every input combination of a small combinational boolean block,
// records its output into a truth table and offers that table to a consumer
// over a val/rdy handshake.
// Optional feature macro: KMAP_SWEEP_CHECK_EN adds an expected-table input
// and a mismatch flag that compares it against the captured table.

module kmap_sweep_capture #(
    parameter  int NBITS = 3,
    localparam int TW    = 2 ** NBITS
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    output logic [NBITS-1:0] dut_in,
    input  logic             dut_f,
    output logic             busy,
    output logic             out_val,
    input  logic             out_rdy,
`ifdef KMAP_SWEEP_CHECK_EN
    input  logic [TW-1:0]    exp_table,
    output logic             mismatch,
`endif
    output logic [TW-1:0]    out_table
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DONE  = 2'd2
    } state_t;

    // idx reaching all-ones marks the last combination of the sweep
    localparam logic [NBITS-1:0] IDX_LAST = {NBITS{1'b1}};

    state_t           state;
    state_t           state_next;
    logic [NBITS-1:0] idx;
    logic [TW-1:0]    table_q;

    // State register; reset aborts any sweep or pending hand-off immediately
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: start only counts in IDLE, so nothing can be queued
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = SWEEP;
                end
            end
            SWEEP: begin
                if (idx == IDX_LAST) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (out_rdy) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Output decode from the current state
    always_comb begin
        busy    = 1'b0;
        out_val = 1'b0;
        case (state)
            SWEEP:   busy = 1'b1;
            DONE: begin
                busy    = 1'b1;
                out_val = 1'b1;
            end
            default: begin
                busy    = 1'b0;
                out_val = 1'b0;
            end
        endcase
    end

    // Sweep datapath: capture f for the presented combination, then advance;
    // idx returns to zero after the last one so IDLE always presents zero
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx     <= '0;
            table_q <= '0;
        end else if (state == SWEEP) begin
            table_q[idx] <= dut_f;
            if (idx == IDX_LAST) begin
                idx <= '0;
            end else begin
                idx <= idx + 1'b1;
            end
        end
    end

    assign dut_in    = idx;
    assign out_table = table_q;

`ifdef KMAP_SWEEP_CHECK_EN
    // Flag a disagreement with the expected table only while the table is offered
    always_comb begin
        mismatch = out_val && (table_q != exp_table);
    end
`endif

endmodule

// File: tb/tb_kmap_sweep_capture.sv
// tb_kmap_sweep_capture
// Table-driven bench for kmap_sweep_capture (NBITS=3) with a few hand-written
// multi-cycle sequences. Builds with or without KMAP_SWEEP_CHECK_EN.

module tb_kmap_sweep_capture;

    logic       clk;
    logic       reset;
    logic       start;
    logic [2:0] dut_in;
    logic       dut_f;
    logic       busy;
    logic       out_val;
    logic       out_rdy;
    logic [7:0] out_table;
`ifdef KMAP_SWEEP_CHECK_EN
    logic [7:0] exp_table;
    logic       mismatch;
`endif

    logic [2:0] func_sel;
    int         assert_count;
    int         fail_count;

    typedef struct {
        logic [2:0] func;
        logic [7:0] expected;
        int         hold;
    } vec_t;

    vec_t vecs[5];

    kmap_sweep_capture #(.NBITS(3)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .dut_in    (dut_in),
        .dut_f     (dut_f),
        .busy      (busy),
        .out_val   (out_val),
        .out_rdy   (out_rdy),
`ifdef KMAP_SWEEP_CHECK_EN
        .exp_table (exp_table),
        .mismatch  (mismatch),
`endif
        .out_table (out_table)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Boolean functions under test, with a = dut_in[2], b = dut_in[1], c = dut_in[0]
    always_comb begin
        case (func_sel)
            3'd0:    dut_f = dut_in[0];
            3'd1:    dut_f = dut_in[2] & dut_in[1];
            3'd2:    dut_f = ~dut_in[2] | dut_in[1] | dut_in[0];
            3'd3:    dut_f = 1'b1;
            3'd4:    dut_f = dut_in[2] ^ dut_in[1] ^ dut_in[0];
            default: dut_f = 1'b0;
        endcase
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        assert_count++;
        if (actual !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Runs one full sweep from IDLE, holds off the consumer for 'hold' cycles,
    // then completes the handshake. Called and returns at 1 time unit after a rising edge.
    task automatic applyStimulus(input logic [2:0] func, input logic [7:0] expected,
                                 input int hold, input logic [7:0] cmp_table,
                                 input logic exp_mis);
        func_sel = func;
        out_rdy  = 1'b0;
`ifdef KMAP_SWEEP_CHECK_EN
        exp_table = cmp_table;
`endif
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        checkOutput("busy_after_start", {31'd0, busy}, 32'd1);
        for (int i = 0; i < 8; i++) begin
            checkOutput("dut_in_order", {29'd0, dut_in}, i);
            checkOutput("out_val_early", {31'd0, out_val}, 32'd0);
            @(posedge clk); #1;
        end
        checkOutput("out_val_rise", {31'd0, out_val}, 32'd1);
        checkOutput("out_table", {24'd0, out_table}, {24'd0, expected});
        checkOutput("dut_in_done", {29'd0, dut_in}, 32'd0);
`ifdef KMAP_SWEEP_CHECK_EN
        checkOutput("mismatch_done", {31'd0, mismatch}, {31'd0, exp_mis});
`endif
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            checkOutput("out_val_hold", {31'd0, out_val}, 32'd1);
            checkOutput("out_table_hold", {24'd0, out_table}, {24'd0, expected});
            checkOutput("busy_hold", {31'd0, busy}, 32'd1);
        end
        out_rdy = 1'b1;
        @(posedge clk); #1;
        out_rdy = 1'b0;
        checkOutput("out_val_after_hs", {31'd0, out_val}, 32'd0);
        checkOutput("busy_after_hs", {31'd0, busy}, 32'd0);
`ifdef KMAP_SWEEP_CHECK_EN
        checkOutput("mismatch_idle", {31'd0, mismatch}, 32'd0);
`endif
        if (cmp_table == 8'h00 && exp_mis) begin
            $display("[TB] note: unusual compare table");
        end
    endtask

    initial begin
        assert_count = 0;
        fail_count   = 0;
        reset    = 1'b1;
        start    = 1'b0;
        out_rdy  = 1'b0;
        func_sel = 3'd0;
`ifdef KMAP_SWEEP_CHECK_EN
        exp_table = 8'h00;
`endif

        vecs[0] = '{3'd0, 8'hAA, 0};
        vecs[1] = '{3'd1, 8'hC0, 0};
        vecs[2] = '{3'd2, 8'hEF, 0};
        vecs[3] = '{3'd3, 8'hFF, 5};
        vecs[4] = '{3'd4, 8'h96, 1};

        // Reset state
        #2;
        checkOutput("reset_busy", {31'd0, busy}, 32'd0);
        checkOutput("reset_out_val", {31'd0, out_val}, 32'd0);
        checkOutput("reset_dut_in", {29'd0, dut_in}, 32'd0);
        checkOutput("reset_table", {24'd0, out_table}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        checkOutput("idle_busy", {31'd0, busy}, 32'd0);

        // Vector table: one sweep per function
        for (int v = 0; v < 5; v++) begin
            applyStimulus(vecs[v].func, vecs[v].expected, vecs[v].hold,
                          vecs[v].expected, 1'b0);
        end

        // Start pulses in SWEEP, DONE and the handshake cycle are all ignored
        func_sel = 3'd1;
`ifdef KMAP_SWEEP_CHECK_EN
        exp_table = 8'hC0;
`endif
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        checkOutput("ign_dut_in_mid", {29'd0, dut_in}, 32'd4);
        repeat (4) begin
            @(posedge clk); #1;
        end
        checkOutput("ign_out_val", {31'd0, out_val}, 32'd1);
        checkOutput("ign_table", {24'd0, out_table}, 32'h0000_00C0);
        start = 1'b1;
        repeat (2) begin
            @(posedge clk); #1;
            checkOutput("ign_done_hold", {31'd0, out_val}, 32'd1);
        end
        out_rdy = 1'b1;
        @(posedge clk); #1;
        start   = 1'b0;
        out_rdy = 1'b0;
        checkOutput("ign_hs_out_val", {31'd0, out_val}, 32'd0);
        checkOutput("ign_hs_busy", {31'd0, busy}, 32'd0);
        repeat (3) begin
            @(posedge clk); #1;
            checkOutput("ign_no_relaunch", {31'd0, busy}, 32'd0);
            checkOutput("ign_no_second_val", {31'd0, out_val}, 32'd0);
        end

        // Asynchronous reset part-way through a sweep
        func_sel = 3'd0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
        end
        checkOutput("abort_idx4", {29'd0, dut_in}, 32'd4);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("abort_dut_in", {29'd0, dut_in}, 32'd0);
        checkOutput("abort_busy", {31'd0, busy}, 32'd0);
        checkOutput("abort_out_val", {31'd0, out_val}, 32'd0);
        checkOutput("abort_table", {24'd0, out_table}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        checkOutput("abort_stays_idle", {31'd0, busy}, 32'd0);
        applyStimulus(3'd0, 8'hAA, 0, 8'hAA, 1'b0);

`ifdef KMAP_SWEEP_CHECK_EN
        // Wrong expected table raises mismatch only while the table is offered
        applyStimulus(3'd0, 8'hAA, 2, 8'hAB, 1'b1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule
